// File: rtl/cla8.sv
// cla8: 8-bit adder built from two 4-bit carry-lookahead groups and a second-level lookahead unit,
// with combinational sum/carry/group flags and registered sum, carry and signed-overflow outputs.
module cla8 (
   output logic       Cout,
   output logic [7:0] S,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Cin,
   input  logic       clk,
   input  logic       rst_n,
   output logic       PG,
   output logic       GG,
   output logic [7:0] S_r,
   output logic       Cout_r,
   output logic       Ovf_r
);
   logic [7:0] g, p, c;
   logic [1:0] grp_p, grp_g;
   logic [7:0] s_q, s_d;
   logic       cout_q, cout_d, ovf_q, ovf_d;
   assign g = A & B;
   assign p = A ^ B;
   assign c[0] = Cin;
   genvar k;
   generate
      for (k = 0; k < 2; k++) begin : grp
         logic [3:0] gl, pl;
         logic       ci;
         assign gl = g[4*k +: 4];
         assign pl = p[4*k +: 4];
         assign ci = c[4*k];
         // internal carries flattened to two-level sum-of-products
         assign c[4*k+1] = gl[0] | (pl[0] & ci);
         assign c[4*k+2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & ci);
         assign c[4*k+3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                         | (pl[2] & pl[1] & pl[0] & ci);
         assign grp_p[k] = &pl;
         assign grp_g[k] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                         | (pl[3] & pl[2] & pl[1] & gl[0]);
      end
   endgenerate
   assign c[4] = grp_g[0] | (grp_p[0] & Cin);
   assign Cout = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & Cin);
   assign PG   = grp_p[1] & grp_p[0];
   assign GG   = grp_g[1] | (grp_p[1] & grp_g[0]);
   assign S    = p ^ c;
   assign s_d    = S;
   assign cout_d = Cout;
   assign ovf_d  = (A[7] == B[7]) & (S[7] != A[7]);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end
   assign S_r    = s_q;
   assign Cout_r = cout_q;
   assign Ovf_r  = ovf_q;
endmodule

// File: tb/tb_cla8.sv
// tb_cla8: vector table, random and exhaustive checks of cla8 against an arithmetic reference model.
module tb_cla8;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] A = '0, B = '0;
   logic       Cin = 1'b0;
   logic [7:0] S, S_r;
   logic       Cout, PG, GG, Cout_r, Ovf_r;
   int         n_cmp = 0, n_bad = 0;

   typedef struct {
      logic [7:0] a, b;
      logic       cin;
      logic [7:0] s;
      logic       cout, pg, gg, ovf;
   } vec_t;

   vec_t tbl[8];

   cla8 dut (.Cout(Cout), .S(S), .A(A), .B(B), .Cin(Cin), .clk(clk), .rst_n(rst_n),
             .PG(PG), .GG(GG), .S_r(S_r), .Cout_r(Cout_r), .Ovf_r(Ovf_r));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (A=%0h B=%0h Cin=%0b)", name, act, exp, A, B, Cin);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values
   function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic cin);
      vec_t v;
      int   u, sv;
      u  = int'(a) + int'(b) + int'(cin);
      sv = (a > 127 ? int'(a) - 256 : int'(a)) + (b > 127 ? int'(b) - 256 : int'(b)) + int'(cin);
      v.a = a; v.b = b; v.cin = cin;
      v.s    = 8'(u % 256);
      v.cout = (u > 255);
      v.pg   = ((a ^ b) == 8'hFF);
      v.gg   = (int'(a) + int'(b) > 255);
      v.ovf  = (sv > 127) || (sv < -128);
      return v;
   endfunction

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      A = v.a; B = v.b; Cin = v.cin;
      #1;
      chk({tag, ".S"}, 32'(S), 32'(v.s));
      chk({tag, ".Cout"}, 32'(Cout), 32'(v.cout));
      chk({tag, ".PG"}, 32'(PG), 32'(v.pg));
      chk({tag, ".GG"}, 32'(GG), 32'(v.gg));
      @(posedge clk);
      #1;
      chk({tag, ".S_r"}, 32'(S_r), 32'(v.s));
      chk({tag, ".Cout_r"}, 32'(Cout_r), 32'(v.cout));
      chk({tag, ".Ovf_r"}, 32'(Ovf_r), 32'(v.ovf));
   endtask

   initial begin
      vec_t v;
      tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};

      // registered outputs cleared while reset is held, even across edges
      A = 8'hFF; B = 8'hFF; Cin = 1'b1;
      #2;
      chk("rst.S_r", 32'(S_r), 32'h0);
      chk("rst.Cout_r", 32'(Cout_r), 32'h0);
      chk("rst.Ovf_r", 32'(Ovf_r), 32'h0);
      chk("rst.S_comb", 32'(S), 32'hFF);
      @(posedge clk);
      #1;
      chk("rst_edge.S_r", 32'(S_r), 32'h0);
      chk("rst_edge.Cout_r", 32'(Cout_r), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("tbl%0d", i));

      for (int i = 0; i < 300; i++) begin
         v = model(8'($urandom), 8'($urandom), 1'($urandom));
         apply(v, "rnd");
      end

      // mid-run asynchronous reset between edges
      apply(model(8'hC3, 8'h9A, 1'b1), "pre_rst");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst.S_r", 32'(S_r), 32'h0);
      chk("mid_rst.Cout_r", 32'(Cout_r), 32'h0);
      chk("mid_rst.Ovf_r", 32'(Ovf_r), 32'h0);
      v = model(8'hC3, 8'h9A, 1'b1);
      chk("mid_rst.S", 32'({Cout, S}), 32'({v.cout, v.s}));
      A = 8'h40; B = 8'h41; Cin = 1'b0;
      v = model(A, B, Cin);
      #1;
      chk("mid_rst.track", 32'({Cout, S}), 32'({v.cout, v.s}));
      @(posedge clk);
      #1;
      chk("mid_rst.hold_S_r", 32'(S_r), 32'h0);
      chk("mid_rst.hold_Ovf_r", 32'(Ovf_r), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst.S_r", 32'(S_r), 32'(v.s));
      chk("post_rst.Ovf_r", 32'(Ovf_r), 32'(v.ovf));

      // exhaustive combinational sweep over all A, B, Cin
      for (int b = 0; b < 256; b++)
         for (int a = 0; a < 256; a++)
            for (int ci = 0; ci < 2; ci++) begin
               A = 8'(a); B = 8'(b); Cin = 1'(ci);
               #1;
               chk("sweep", 32'({Cout, S}), 32'(a + b + ci));
            end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cla8.md
CLA8 -- requirements
Module: cla8

Interface
REQ-001 Parameters: none; operand width is fixed at 8 bits and the lookahead group size is fixed at 4 bits.
REQ-002 clk  input  1  single clock; all registers update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 A  input  8  unsigned addend A.
REQ-005 B  input  8  unsigned addend B.
REQ-006 Cin  input  1  carry into bit 0.
REQ-007 S  output  8  combinational sum, (A+B+Cin) mod 256.
REQ-008 Cout  output  1  combinational carry out of bit 7.
REQ-009 PG  output  1  combinational group propagate: AND over all eight (A[i] XOR B[i]).
REQ-010 GG  output  1  combinational group generate of the 8-bit block, independent of Cin.
REQ-011 S_r  output  8  registered copy of S.
REQ-012 Cout_r  output  1  registered copy of Cout.
REQ-013 Ovf_r  output  1  registered two's-complement overflow flag.
REQ-014 Port declaration order: Cout, S, A, B, Cin, clk, rst_n, PG, GG, S_r, Cout_r, Ovf_r; positional instantiation (Cout, S, A, B, Cin, ...) binds correctly.

Function
REQ-015 The sum path is carry-lookahead, not ripple: per-bit generate g[i] = A[i] AND B[i]; per-bit propagate p[i] = A[i] XOR B[i].
REQ-016 The sum path uses two 4-bit CLA groups (bits 3:0 and 7:4); each group computes its internal carries c[i+1] = g[i] OR (p[i] AND c[i]), flattened into two-level sum-of-products.
REQ-017 Each group exports a group propagate P (AND of its p[i]) and a group generate G.
REQ-018 A second-level lookahead unit computes c4 = G0 OR (P0 AND Cin) and Cout = G1 OR (P1 AND G0) OR (P1 AND P0 AND Cin).
REQ-019 PG = P1 AND P0.
REQ-020 GG = G1 OR (P1 AND G0).
REQ-021 S[i] = p[i] XOR c[i], with c[0] = Cin.
REQ-022 {Cout, S} equals the 9-bit value A + B + Cin for all 2^17 input combinations.
REQ-023 S, Cout, PG and GG are purely combinational: zero latency, no dependence on clk or rst_n.
REQ-024 On each rising clk edge with rst_n high, S_r <= S and Cout_r <= Cout.
REQ-025 On each rising clk edge with rst_n high, Ovf_r <= (A[7] == B[7]) AND (S[7] != A[7]).
REQ-026 The registered outputs have exactly one cycle of latency.
REQ-027 Wrap-around: 255 + 0 + 1 gives S = 0, Cout = 1; 255 + 255 + 1 gives S = 255, Cout = 1.
REQ-028 X or Z on any input may propagate to the outputs; no masking is required.

Reset
REQ-029 While rst_n = 0, S_r = 0, Cout_r = 0 and Ovf_r = 0 immediately, without waiting for a clock edge.
REQ-030 Reset does not affect the combinational outputs S, Cout, PG or GG.
REQ-031 Deassertion of rst_n is synchronised externally.
REQ-032 The first capture after reset occurs on the first rising clk edge with rst_n high.

Verification
REQ-033 A=0, B=0, Cin=0 -> S=0, Cout=0, PG=0, GG=0.
REQ-034 A=8'hFF, B=8'h00, Cin=1 -> S=0, Cout=1, PG=1, GG=0 (full-propagate chain).
REQ-035 A=8'h80, B=8'h80, Cin=0 -> S=0, Cout=1, GG=1; next edge -> S_r=0, Cout_r=1, Ovf_r=1.
REQ-036 A=8'h7F, B=8'h01, Cin=0 -> S=8'h80, Cout=0; next edge -> Ovf_r=1.
REQ-037 Exhaustive sweep: A steps 0..255, B increments every 256 A steps, Cin toggled -> S and Cout match A+B+Cin with zero mismatches.
REQ-038 Assert rst_n=0 mid-sweep between clock edges -> S_r, Cout_r, Ovf_r go to 0 at once while S and Cout continue to track the inputs.
